// File: rtl/axi_typed_unpacker_pkg.sv
// Shared types and width helpers for the typed AXI4S unpacker.
// Element widths are 8/16/32/64 bits; anything unrecognised is treated as 64-bit.
package axi_typed_unpacker_pkg;

    typedef logic [63:0] data64_t;

    typedef enum logic [2:0] {
        TYPE_U8  = 3'd0,
        TYPE_U16 = 3'd1,
        TYPE_U32 = 3'd2,
        TYPE_U64 = 3'd3,
        TYPE_F32 = 3'd4,
        TYPE_F64 = 3'd5
    } type_t;

    localparam int MAX_RATIO = 8;

    function automatic int GET_TYPE_WIDTH(type_t t);
        case (t)
            TYPE_U8:            return 8;
            TYPE_U16:           return 16;
            TYPE_U32, TYPE_F32: return 32;
            default:            return 64;
        endcase
    endfunction

    function automatic int TYPE_RATIO(type_t t);
        return 64 / GET_TYPE_WIDTH(t);
    endfunction

    // Compact width code: 0=8, 1=16, 2=32, 3=64 bits.
    function automatic logic [1:0] TYPE_WIDTH_CODE(type_t t);
        case (GET_TYPE_WIDTH(t))
            8:       return 2'd0;
            16:      return 2'd1;
            32:      return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/axi_typed_unpacker_lane_extract.sv
// Combinational slicer: picks sub-beat `sub` out of a buffered AXI beat and
// zero-extends each element into a 64-bit lane, with per-lane and per-sub-beat keep.
module typed_lane_extract
    import axi_typed_unpacker_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8
) (
    input  logic [64*NUM_ELEMENTS-1:0]  beat_data,
    input  logic [8*NUM_ELEMENTS-1:0]   beat_keep,
    input  logic [2:0]                  sub,
    input  logic [1:0]                  wcode,
    output data64_t [NUM_ELEMENTS-1:0]  lane_data,
    output logic [NUM_ELEMENTS-1:0]     lane_keep,
    output logic [MAX_RATIO-1:0]        nonempty
);

    localparam int NE = 8 * NUM_ELEMENTS;

    logic [NE-1:0]                 ek8, ek16, ek32, ek64, elem_keep;
    logic [31:0]                   elem_base;
    logic [31:0]                   bit_shift;
    logic [64*NUM_ELEMENTS-1:0]    sub_data;

    // Element keep = lowest tkeep byte of each element; zero past the beat's element count.
    for (genvar e = 0; e < NE; e++) begin : g_ek
        assign ek8[e] = beat_keep[e];
        if (e < NE / 2) begin : g_in16
            assign ek16[e] = beat_keep[2*e];
        end else begin : g_out16
            assign ek16[e] = 1'b0;
        end
        if (e < NE / 4) begin : g_in32
            assign ek32[e] = beat_keep[4*e];
        end else begin : g_out32
            assign ek32[e] = 1'b0;
        end
        if (e < NE / 8) begin : g_in64
            assign ek64[e] = beat_keep[8*e];
        end else begin : g_out64
            assign ek64[e] = 1'b0;
        end
    end

    always_comb begin
        case (wcode)
            2'd0:    elem_keep = ek8;
            2'd1:    elem_keep = ek16;
            2'd2:    elem_keep = ek32;
            default: elem_keep = ek64;
        endcase
    end

    assign elem_base = 32'(sub) * 32'(NUM_ELEMENTS);
    assign bit_shift = elem_base << (32'd3 + 32'(wcode));
    assign sub_data  = beat_data >> bit_shift;
    assign lane_keep = NUM_ELEMENTS'(elem_keep >> elem_base);

    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
        logic [63:0] lane_v;
        always_comb begin
            case (wcode)
                2'd0:    lane_v = 64'(sub_data[i*8 +: 8]);
                2'd1:    lane_v = 64'(sub_data[i*16 +: 16]);
                2'd2:    lane_v = 64'(sub_data[i*32 +: 32]);
                default: lane_v = sub_data[i*64 +: 64];
            endcase
        end
        assign lane_data[i] = lane_v;
    end

    for (genvar k = 0; k < MAX_RATIO; k++) begin : g_ne
        assign nonempty[k] = |elem_keep[k*NUM_ELEMENTS +: NUM_ELEMENTS];
    end

endmodule

// File: rtl/axi_typed_unpacker.sv
// Buffered typed unpacker: registers one AXI4S beat and emits it as R = 64/W
// sub-beats of NUM_ELEMENTS zero-extended 64-bit lanes, skipping trailing empty sub-beats on tlast.
module axi_typed_unpacker
    import axi_typed_unpacker_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  type_t                       actual_type_data,
    input  logic                        actual_type_valid,
    output logic                        actual_type_ready,
    input  logic [64*NUM_ELEMENTS-1:0]  in_tdata,
    input  logic [8*NUM_ELEMENTS-1:0]   in_tkeep,
    input  logic                        in_tlast,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    output data64_t [NUM_ELEMENTS-1:0]  out_data,
    output logic [NUM_ELEMENTS-1:0]     out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic [64*NUM_ELEMENTS-1:0] buf_data;
    logic [8*NUM_ELEMENTS-1:0]  buf_keep;
    logic                       buf_last;
    logic                       buf_full;
    logic                       in_stream;
    logic                       active;
    logic [2:0]                 sub;
    logic [2:0]                 r_m1_q;
    logic [1:0]                 w_q;
    logic [MAX_RATIO-1:0]       nonempty;
    logic [2:0]                 last_idx;
    logic                       out_hs, final_sub, load, stream_end;

    typed_lane_extract #(.NUM_ELEMENTS(NUM_ELEMENTS)) u_extract (
        .beat_data (buf_data),
        .beat_keep (buf_keep),
        .sub       (sub),
        .wcode     (w_q),
        .lane_data (out_data),
        .lane_keep (out_keep),
        .nonempty  (nonempty)
    );

    always_comb begin
        last_idx = 3'd0;
        for (int k = 0; k < MAX_RATIO; k++) begin
            if (nonempty[k]) last_idx = 3'(k);
        end
    end

    // All channels use valid/ready: a transfer happens on a clock edge where both are high;
    // valid never depends on ready, and payload is held stable while valid && !ready.
    assign out_valid         = buf_full;
    assign out_last          = buf_full && buf_last && (sub == last_idx);
    assign out_hs            = out_valid && out_ready;
    assign final_sub         = (sub == r_m1_q) || out_last;
    assign in_tready         = active && actual_type_valid && (!buf_full || (out_hs && final_sub));
    assign load              = in_tvalid && in_tready;
    assign stream_end        = out_hs && out_last;
    assign actual_type_ready = stream_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            buf_full  <= 1'b0;
            buf_last  <= 1'b0;
            in_stream <= 1'b0;
            sub       <= 3'd0;
            w_q       <= 2'd3;
            r_m1_q    <= 3'd0;
        end else begin
            active <= 1'b1;
            if (load) begin
                buf_full <= 1'b1;
                buf_last <= in_tlast;
                sub      <= 3'd0;
                // Width is fixed at the first beat of a stream and ignored until out_last.
                if (!in_stream || stream_end) begin
                    w_q    <= TYPE_WIDTH_CODE(actual_type_data);
                    r_m1_q <= 3'(TYPE_RATIO(actual_type_data) - 1);
                end
            end else if (out_hs) begin
                if (final_sub) begin
                    buf_full <= 1'b0;
                    sub      <= 3'd0;
                end else begin
                    sub <= sub + 3'd1;
                end
            end
            if (load) in_stream <= 1'b1;
            else if (stream_end) in_stream <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            buf_data <= in_tdata;
            buf_keep <= in_tkeep;
        end
    end

endmodule

// File: tb/tb_axi_typed_unpacker.sv
// Self-checking bench for axi_typed_unpacker: vector table plus hand-written
// multi-cycle sequences, all outputs checked through an expected-value queue.
module tb_axi_typed_unpacker;
    import axi_typed_unpacker_pkg::*;

    localparam int N  = 8;
    localparam int DW = 64 * N;
    localparam int KW = 8 * N;

    logic                clk = 1'b0;
    logic                rst_n;
    type_t               at_data;
    logic                at_valid, at_ready;
    logic [DW-1:0]       in_tdata;
    logic [KW-1:0]       in_tkeep;
    logic                in_tlast, in_tvalid, in_tready;
    data64_t [N-1:0]     out_data;
    logic [N-1:0]        out_keep;
    logic                out_last, out_valid, out_ready;

    typedef struct {
        logic [DW-1:0] data;
        logic [N-1:0]  keep;
        logic          last;
    } exp_t;

    typedef struct {
        type_t         t;
        int            w;
        int            pat;
        logic [KW-1:0] keep;
        int            exp_n;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    int   n_type_ready = 0;
    int   ready_mode = 0;
    int   cyc = 0;

    logic          held_pending = 1'b0;
    logic [DW-1:0] held_data;
    logic [N-1:0]  held_keep;
    logic          held_last;

    axi_typed_unpacker #(.NUM_ELEMENTS(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .actual_type_data  (at_data),
        .actual_type_valid (at_valid),
        .actual_type_ready (at_ready),
        .in_tdata          (in_tdata),
        .in_tkeep          (in_tkeep),
        .in_tlast          (in_tlast),
        .in_tvalid         (in_tvalid),
        .in_tready         (in_tready),
        .out_data          (out_data),
        .out_keep          (out_keep),
        .out_last          (out_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Output ready pattern; mode 3 leaves out_ready to the test sequence
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input int act, input int exp);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    // Reference model: expected sub-beats for one beat at element width w
    task automatic push_model(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input int w);
        logic [DW-1:0] one, m;
        int r, lidx, nsub, e;
        logic any;
        exp_t x;
        one = 1;
        m = (one << w) - 1;
        r = 64 / w;
        lidx = 0;
        if (l) begin
            for (int s = 0; s < r; s++) begin
                any = 1'b0;
                for (int i = 0; i < N; i++) begin
                    e = s * N + i;
                    if (k[e*w/8]) any = 1'b1;
                end
                if (any) lidx = s;
            end
        end
        nsub = l ? lidx + 1 : r;
        for (int s = 0; s < nsub; s++) begin
            x.data = '0;
            x.keep = '0;
            for (int i = 0; i < N; i++) begin
                e = s * N + i;
                x.data[i*64 +: 64] = 64'((d >> (e * w)) & m);
                x.keep[i] = k[e*w/8];
            end
            x.last = l && (s == lidx);
            exp_q.push_back(x);
        end
    endtask

    function automatic logic [DW-1:0] make_data(input int pat, input int w);
        logic [DW-1:0] d, one, m, ev;
        d = '0;
        one = 1;
        m = (one << w) - 1;
        if (pat == 0) begin
            for (int e = 0; e < DW / w; e++) begin
                ev = DW'(e);
                d = d | ((ev & m) << (e * w));
            end
        end else begin
            for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
        end
        return d;
    endfunction

    // Driver: offer a beat, wait for its handshake; tvalid stays up afterwards
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input int w, output int hs_cyc);
        logic hs;
        push_model(d, k, l, w);
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_tvalid = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            hs = in_tready;
            @(posedge clk);
            #1;
            if (hs) break;
            if (n > 300) begin
                fail_msg("beat_accept_timeout", n, 0);
                break;
            end
        end
        hs_cyc = cyc;
    endtask

    task automatic in_idle();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_msg("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stream_end(input int t0);
        int n;
        n = 0;
        while (n_type_ready <= t0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_msg("type_ready_timeout", n_type_ready, t0 + 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            held_pending = 1'b0;
        end else begin
            if (held_pending) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_stable", out_data, held_data);
                chk("stall_keep_stable", out_keep, held_keep);
                chk("stall_last_stable", out_last, held_last);
            end
            if (out_valid && in_tready) chk("tready_only_on_out_handshake", out_ready, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("out_data", out_data, x.data);
                    chk("out_keep", out_keep, x.keep);
                    chk("out_last", out_last, x.last);
                end
                n_out++;
            end
            if (at_ready) n_type_ready++;
            held_pending = out_valid && !out_ready;
            held_data    = out_data;
            held_keep    = out_keep;
            held_last    = out_last;
        end
    end

    initial begin
        vec_t vt[8];
        int c0, c1, c2, c3, n0, t0;

        vt[0] = '{TYPE_U64, 64, 1, {KW{1'b1}},               1};
        vt[1] = '{TYPE_U32, 32, 0, {KW{1'b1}},               2};
        vt[2] = '{TYPE_U8,   8, 0, 64'h0000_0000_0000_FFFF, 2};
        vt[3] = '{TYPE_U16, 16, 1, {KW{1'b1}},               4};
        vt[4] = '{TYPE_U16, 16, 1, 64'h0000_0000_0000_FFFF, 1};
        vt[5] = '{TYPE_U8,   8, 1, 64'h0,                   1};
        vt[6] = '{TYPE_F32, 32, 1, 64'h0000_000F_FFFF_FFFF, 2};
        vt[7] = '{TYPE_F64, 64, 1, 64'h0000_0000_0000_00FF, 1};

        // Reset state
        rst_n     = 1'b0;
        at_data   = TYPE_U64;
        at_valid  = 1'b1;
        in_tdata  = '0;
        in_tkeep  = '0;
        in_tlast  = 1'b0;
        in_tvalid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_tready", in_tready, 0);
        chk("reset_type_ready", at_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single-beat streams
        for (int v = 0; v < 8; v++) begin
            at_data = vt[v].t;
            n0 = n_out;
            t0 = n_type_ready;
            send_beat(make_data(vt[v].pat, vt[v].w), vt[v].keep, 1'b1, vt[v].w, c0);
            in_idle();
            wait_drain();
            chk($sformatf("vec%0d_out_count", v), n_out - n0, vt[v].exp_n);
            chk($sformatf("vec%0d_type_ready", v), n_type_ready - t0, 1);
        end

        // W=64: four beats at full rate, one-cycle latency
        at_data = TYPE_U64;
        n0 = n_out;
        t0 = n_type_ready;
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b0, 64, c0);
        chk("w64_latency_valid", out_valid, 1);
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b0, 64, c1);
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b0, 64, c2);
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b1, 64, c3);
        in_idle();
        wait_drain();
        chk("w64_full_rate", c3 - c0, 3);
        chk("w64_out_count", n_out - n0, 4);
        chk("w64_type_ready", n_type_ready - t0, 1);

        // W=32: next beat waits for the second sub-beat
        at_data = TYPE_U32;
        send_beat(make_data(0, 32), {KW{1'b1}}, 1'b1, 32, c0);
        send_beat(make_data(1, 32), {KW{1'b1}}, 1'b1, 32, c1);
        in_idle();
        wait_drain();
        chk("w32_second_load_gap", c1 - c0, 2);

        // W=8 with 16 keep bytes: two sub-beats, next beat taken on the last one
        at_data = TYPE_U8;
        n0 = n_out;
        t0 = n_type_ready;
        send_beat(make_data(0, 8), 64'h0000_0000_0000_FFFF, 1'b1, 8, c0);
        send_beat(make_data(1, 8), 64'h0000_0000_0000_00FF, 1'b1, 8, c1);
        in_idle();
        wait_drain();
        chk("w8_skip_load_gap", c1 - c0, 2);
        chk("w8_skip_out_count", n_out - n0, 3);
        chk("w8_skip_type_ready", n_type_ready - t0, 2);

        // W=16 with toggling ready, then W=8 with random ready
        ready_mode = 1;
        at_data = TYPE_U16;
        n0 = n_out;
        send_beat(make_data(1, 16), {KW{1'b1}}, 1'b0, 16, c0);
        send_beat(make_data(1, 16), {KW{1'b1}}, 1'b0, 16, c0);
        send_beat(make_data(1, 16), {KW{1'b1}}, 1'b1, 16, c0);
        in_idle();
        wait_drain();
        chk("w16_toggle_out_count", n_out - n0, 12);
        ready_mode = 2;
        at_data = TYPE_U8;
        n0 = n_out;
        send_beat(make_data(1, 8), {KW{1'b1}}, 1'b0, 8, c0);
        send_beat(make_data(1, 8), {KW{1'b1}}, 1'b1, 8, c0);
        in_idle();
        wait_drain();
        chk("w8_random_out_count", n_out - n0, 16);
        ready_mode = 0;

        // Back-to-back streams W=32 then W=64; mid-stream type change ignored
        at_data = TYPE_U32;
        n0 = n_out;
        t0 = n_type_ready;
        send_beat(make_data(1, 32), {KW{1'b1}}, 1'b0, 32, c0);
        at_data = TYPE_U8;
        send_beat(make_data(1, 32), {KW{1'b1}}, 1'b1, 32, c0);
        in_idle();
        wait_stream_end(t0);
        at_data = TYPE_U64;
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b0, 64, c0);
        send_beat(make_data(1, 64), {KW{1'b1}}, 1'b1, 64, c0);
        in_idle();
        wait_drain();
        chk("b2b_out_count", n_out - n0, 6);
        chk("b2b_type_ready", n_type_ready - t0, 2);

        // Reset while a W=8 beat sits at sub=2
        ready_mode = 3;
        out_ready = 1'b0;
        at_data = TYPE_U8;
        n0 = n_out;
        send_beat(make_data(1, 8), {KW{1'b1}}, 1'b1, 8, c0);
        in_idle();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("pre_reset_out_count", n_out - n0, 2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_tready", in_tready, 0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ready_mode = 0;
        n0 = n_out;
        t0 = n_type_ready;
        send_beat(make_data(0, 8), 64'h0000_0000_0000_00FF, 1'b1, 8, c0);
        in_idle();
        wait_drain();
        chk("post_reset_out_count", n_out - n0, 1);
        chk("post_reset_type_ready", n_type_ready - t0, 1);

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
